// File: rtl/cond_unit.sv
// cond_unit
// ---------
// Condition-check and flag-state block. It holds the architectural NZCV flags
// and evaluates each instruction's 4-bit condition field against them. The
// decoder strobes are gated into PCSrc/RegWrite/MemWrite, and NZCV is
// reloaded from ALUFlags when the instruction passes and asks for a flag write.
//
// Optional feature macro: COND_FAILCNT_EN. When defined, it adds a 16-bit
// failed-condition counter (FailCnt) and its synchronous clear (FailCnt_clr).
//
// Parameters:
//   FLAG_RST     reset value of {N,Z,C,V}
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   en           instruction-advance strobe; low stalls all state updates
//   Cond[3:0]    condition field (instruction bits [31:28])
//   ALUFlags[3:0] {N,Z,C,V} from the ALU, same cycle
//   FlagW[1:0]   [1] writes N,Z; [0] writes C,V
//   PCS/RegW/MemW decoder write strobes
//   NoWrite      compare-class instruction; suppresses RegWrite
//   PCSrc/RegWrite/MemWrite gated strobes (combinational)
//   CondEx       combinational condition result
//   CondEx_q     CondEx registered on en
//   Flags[3:0]   current architectural {N,Z,C,V}
//   FailCnt[15:0], FailCnt_clr  (only with COND_FAILCNT_EN)
module cond_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        NoWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
  output logic        CondEx_q,
  output logic [3:0]  Flags
`ifdef COND_FAILCNT_EN
  ,
  input  logic        FailCnt_clr,
  output logic [15:0] FailCnt
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition decode always uses the registered flags, never ALUFlags, so
  // an instruction that sets flags is evaluated against the old ones.
  always_comb begin
    cond_ex = 1'b1;
    case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      default: cond_ex = 1'b1;  // AL and the 1111 encoding
    endcase
  end

  // Each flag half is written independently; unselected halves hold.
  always_comb begin
    flags_d = flags_q;
    if (en && cond_ex) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_comb begin
    cond_ex_d = cond_ex_q;
    if (en) cond_ex_d = cond_ex;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= FLAG_RST;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Strobes are deliberately not qualified by en; the datapath applies its
  // own stage enable.
  assign PCSrc    = PCS & cond_ex;
  assign RegWrite = RegW & cond_ex & ~NoWrite;
  assign MemWrite = MemW & cond_ex;
  assign CondEx   = cond_ex;
  assign CondEx_q = cond_ex_q;
  assign Flags    = flags_q;

`ifdef COND_FAILCNT_EN
  logic [15:0] fail_cnt_q, fail_cnt_d;

  // Clear wins over increment; the increment wraps naturally at 16 bits.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (FailCnt_clr) fail_cnt_d = 16'd0;
    else if (en && !cond_ex) fail_cnt_d = fail_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fail_cnt_q <= 16'd0;
    else       fail_cnt_q <= fail_cnt_d;
  end

  assign FailCnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx, CondEx_q;
  logic [3:0] Flags;
`ifdef COND_FAILCNT_EN
  logic        FailCnt_clr;
  logic [15:0] FailCnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cond_unit #(.FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .CondEx_q(CondEx_q), .Flags(Flags)
`ifdef COND_FAILCNT_EN
    , .FailCnt_clr(FailCnt_clr), .FailCnt(FailCnt)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: conditions come in complementary pairs; the odd code is the
  // inverse of the even one, except the always-true pair 111x.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [3:0] ref_update(input logic [3:0] f, input logic [1:0] w,
                                            input logic [3:0] a);
    logic [3:0] r;
    r = f;
    if (w[1]) r[3:2] = a[3:2];
    if (w[0]) r[1:0] = a[1:0];
    return r;
  endfunction

  typedef struct {
    logic [3:0] cond;
    logic [1:0] flagw;
    logic [3:0] alu;
    logic       pcs, regw, memw, nowrite;
    logic       exp_cx;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[8];

  task automatic drive(input logic e, input logic [3:0] c, input logic [1:0] w,
                       input logic [3:0] a, input logic p, input logic r,
                       input logic m, input logic nw);
    en = e; Cond = c; FlagW = w; ALUFlags = a;
    PCS = p; RegW = r; MemW = m; NoWrite = nw;
  endtask

  logic [3:0] mflags;
  logic       mcq, ecx;

  initial begin
    vecs[0] = '{4'hE, 2'b11, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[1] = '{4'h0, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[2] = '{4'hE, 2'b01, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0111};
    vecs[3] = '{4'hE, 2'b11, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000};
    vecs[4] = '{4'hA, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};
    vecs[5] = '{4'hB, 2'b10, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100};
    vecs[6] = '{4'h1, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100};
    vecs[7] = '{4'hD, 2'b01, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111};

`ifdef COND_FAILCNT_EN
    FailCnt_clr = 1'b0;
`endif
    // Reset state
    reset = 1'b1;
    drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check("rst_flags", {12'd0, Flags}, 16'h0);
    check("rst_condex", {15'd0, CondEx}, 16'h0);
    check("rst_condex_q", {15'd0, CondEx_q}, 16'h0);
    check("rst_pcsrc", {15'd0, PCSrc}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].cond, vecs[i].flagw, vecs[i].alu, vecs[i].pcs,
            vecs[i].regw, vecs[i].memw, vecs[i].nowrite);
      #1;
      check($sformatf("vec%0d_condex", i), {15'd0, CondEx}, {15'd0, vecs[i].exp_cx});
      check($sformatf("vec%0d_pcsrc", i), {15'd0, PCSrc}, {15'd0, vecs[i].pcs & vecs[i].exp_cx});
      check($sformatf("vec%0d_regwrite", i), {15'd0, RegWrite},
            {15'd0, vecs[i].regw & vecs[i].exp_cx & ~vecs[i].nowrite});
      check($sformatf("vec%0d_memwrite", i), {15'd0, MemWrite}, {15'd0, vecs[i].memw & vecs[i].exp_cx});
      @(posedge clk); #1;
      check($sformatf("vec%0d_flags", i), {12'd0, Flags}, {12'd0, vecs[i].exp_flags});
      check($sformatf("vec%0d_condex_q", i), {15'd0, CondEx_q}, {15'd0, vecs[i].exp_cx});
    end

    // Stall: flags are 0111. A failing instruction loads CondEx_q=0, then a
    // stalled AL write must change nothing but still drive the strobes.
    drive(1'b1, 4'h1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("stall_pre_cq", {15'd0, CondEx_q}, 16'h0);
    drive(1'b0, 4'hE, 2'b11, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("stall_condex", {15'd0, CondEx}, 16'h1);
    check("stall_pcsrc", {15'd0, PCSrc}, 16'h1);
    @(posedge clk); #1;
    check("stall_flags", {12'd0, Flags}, 16'h7);
    check("stall_cq", {15'd0, CondEx_q}, 16'h0);

    // Back-to-back flag writes, each visible after its own edge
    drive(1'b1, 4'hE, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b_first", {12'd0, Flags}, 16'hA);
    check("b2b_cq", {15'd0, CondEx_q}, 16'h1);
    drive(1'b1, 4'hE, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("b2b_old_seen", {12'd0, Flags}, 16'hA);
    @(posedge clk); #1;
    check("b2b_second", {12'd0, Flags}, 16'h5);

    // Asynchronous reset overriding a pending write
    drive(1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_flags_now", {12'd0, Flags}, 16'h0);
    check("arst_cq_now", {15'd0, CondEx_q}, 16'h0);
    @(posedge clk); #1;
    check("arst_flags_edge", {12'd0, Flags}, 16'h0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("arst_release_write", {12'd0, Flags}, 16'hF);

    // Sweep every Cond against every flag value
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, 4'hE, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      for (int c = 0; c < 16; c++) begin
        drive(1'b0, 4'(c), 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        #1;
        ecx = ref_pass(4'(c), 4'(f));
        check($sformatf("sweep_c%0d_f%0d", c, f), {15'd0, CondEx}, {15'd0, ecx});
        check($sformatf("sweep_rw_c%0d_f%0d", c, f), {15'd0, RegWrite}, {15'd0, ecx & ~NoWrite});
      end
    end

    // Randomized run against the reference model
    mflags = 4'hF;
    mcq    = 1'b0;
    drive(1'b1, 4'hE, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    mcq = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      ecx = ref_pass(Cond, mflags);
      check("rnd_condex", {15'd0, CondEx}, {15'd0, ecx});
      check("rnd_strobes", {13'd0, PCSrc, RegWrite, MemWrite},
            {13'd0, PCS & ecx, RegW & ecx & ~NoWrite, MemW & ecx});
      @(posedge clk);
      if (en && ecx) mflags = ref_update(mflags, FlagW, ALUFlags);
      if (en) mcq = ecx;
      #1;
      check("rnd_flags", {12'd0, Flags}, {12'd0, mflags});
      check("rnd_condex_q", {15'd0, CondEx_q}, {15'd0, mcq});
    end

`ifdef COND_FAILCNT_EN
    // Failure counter: wrap, clear priority, stall hold, reset
    reset = 1'b1;
    drive(1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (65537) @(posedge clk);
    #1;
    check("fc_wrap", FailCnt, 16'd1);
    FailCnt_clr = 1'b1;
    @(posedge clk); #1;
    check("fc_clr_priority", FailCnt, 16'd0);
    FailCnt_clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("fc_count5", FailCnt, 16'd5);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("fc_stall_hold", FailCnt, 16'd5);
    #2 reset = 1'b1;
    #1;
    check("fc_reset", FailCnt, 16'd0);
    #2 reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
